// File: rtl/sweep_sched.sv
// Linear echo-delay sweep scheduler: steps the pulse-gen delay through
// npts points, holding each for nshots pulse periods.
module sweep_sched #(
    parameter int DEL_W  = 16,
    parameter int PT_W   = 8,
    parameter int SHOT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [DEL_W-1:0]  cfg_start,
    input  logic [DEL_W-1:0]  cfg_step,
    input  logic [PT_W-1:0]   cfg_npts,
    input  logic [SHOT_W-1:0] cfg_nshots,
    input  logic              start,
    input  logic              abort,
    input  logic              cycle_end,
    output logic [DEL_W-1:0]  del_out,
    output logic              del_upd,
    output logic [PT_W-1:0]   pt_idx,
    output logic [SHOT_W-1:0] shot_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [DEL_W-1:0]  sh_start, sh_start_n;
    logic [DEL_W-1:0]  sh_step, sh_step_n;
    logic [PT_W-1:0]   sh_npts, sh_npts_n;
    logic [SHOT_W-1:0] sh_nshots, sh_nshots_n;
    logic [DEL_W-1:0]  del_n;
    logic              upd_n;
    logic [PT_W-1:0]   pt_n;
    logic [SHOT_W-1:0] shot_n;
    logic              err_n;
    logic [DEL_W:0]    sum;
    logic              cfg_ok;
    logic              last_shot;
    logic              last_pt;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    assign cfg_ok    = (sh_npts != '0) && (sh_nshots != '0);
    assign last_shot = (shot_idx == sh_nshots - SHOT_W'(1));
    assign last_pt   = (pt_idx == sh_npts - PT_W'(1));
    assign sum       = {1'b0, del_out} + {1'b0, sh_step};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sh_start  <= '0;
            sh_step   <= '0;
            sh_npts   <= '0;
            sh_nshots <= '0;
            del_out   <= '0;
            del_upd   <= 1'b0;
            pt_idx    <= '0;
            shot_idx  <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            sh_start  <= sh_start_n;
            sh_step   <= sh_step_n;
            sh_npts   <= sh_npts_n;
            sh_nshots <= sh_nshots_n;
            del_out   <= del_n;
            del_upd   <= upd_n;
            pt_idx    <= pt_n;
            shot_idx  <= shot_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        sh_start_n  = sh_start;
        sh_step_n   = sh_step;
        sh_npts_n   = sh_npts;
        sh_nshots_n = sh_nshots;
        del_n       = del_out;
        upd_n       = 1'b0;
        pt_n        = pt_idx;
        shot_n      = shot_idx;
        err_n       = err;

        unique case (state)
            IDLE, DONE: begin
                // start evaluates the shadow as it was before any same-cycle load
                if (start) begin
                    if (!cfg_ok) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = RUN;
                        del_n   = sh_start;
                        pt_n    = '0;
                        shot_n  = '0;
                        upd_n   = 1'b1;
                        err_n   = 1'b0;
                    end
                end else if (cfg_load && state == DONE) begin
                    state_n = IDLE;
                end
                if (cfg_load) begin
                    sh_start_n  = cfg_start;
                    sh_step_n   = cfg_step;
                    sh_npts_n   = cfg_npts;
                    sh_nshots_n = cfg_nshots;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cycle_end) begin
                    if (!last_shot) begin
                        shot_n = shot_idx + SHOT_W'(1);
                    end else if (last_pt) begin
                        state_n = DONE;
                    end else begin
                        shot_n = '0;
                        pt_n   = pt_idx + PT_W'(1);
                        upd_n  = 1'b1;
                        if (sum[DEL_W]) begin
                            del_n = '1;
                            err_n = 1'b1;
                        end else begin
                            del_n = sum[DEL_W-1:0];
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sweep_sched.sv
// Randomized scoreboard bench for sweep_sched against a point-formula
// reference model of the sweep.
module tb_sweep_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load, start, abort, cycle_end;
    logic [15:0] cfg_start, cfg_step;
    logic [7:0]  cfg_npts;
    logic [15:0] cfg_nshots;
    logic [15:0] del_out;
    logic        del_upd;
    logic [7:0]  pt_idx;
    logic [15:0] shot_idx;
    logic        busy, done, err;

    always #5 clk = ~clk;

    sweep_sched #(.DEL_W(16), .PT_W(8), .SHOT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_load(cfg_load), .cfg_start(cfg_start), .cfg_step(cfg_step),
        .cfg_npts(cfg_npts), .cfg_nshots(cfg_nshots),
        .start(start), .abort(abort), .cycle_end(cycle_end),
        .del_out(del_out), .del_upd(del_upd), .pt_idx(pt_idx),
        .shot_idx(shot_idx), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [15:0] del;
        logic [7:0]  pt;
    } upd_t;

    upd_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int upd_seen = 0;

    // model: 0 idle, 1 run, 2 done
    int          m_state;
    int          m_pt, m_shot;
    logic [15:0] m_del;
    bit          m_err;
    logic [15:0] s_start, s_step, s_nshots;
    logic [7:0]  s_npts;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        upd_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && del_upd === 1'b1) begin
                upd_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_upd: got del %0h expected none",
                             del_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("upd_del", 32'(del_out), 32'(e.del));
                    chk("upd_pt", 32'(pt_idx), 32'(e.pt));
                end
            end
        end
    end

    task automatic model_reset();
        m_state = 0; m_pt = 0; m_shot = 0; m_del = 0; m_err = 0;
        s_start = 0; s_step = 0; s_npts = 0; s_nshots = 0;
        exp_q.delete();
    endtask

    // point p is applied at start + p*step, clipped to 0xFFFF on overflow
    task automatic model_step(input bit ld, input bit st,
                              input bit ab, input bit ce);
        longint v;
        if (m_state != 1) begin
            if (st) begin
                if (s_npts == 0 || s_nshots == 0) begin
                    m_err = 1;
                    m_state = 0;
                end else begin
                    m_state = 1;
                    m_pt = 0;
                    m_shot = 0;
                    m_del = s_start;
                    m_err = 0;
                    exp_q.push_back('{s_start, 8'd0});
                end
            end else if (ld && m_state == 2) begin
                m_state = 0;
            end
            if (ld) begin
                s_start = cfg_start; s_step = cfg_step;
                s_npts = cfg_npts; s_nshots = cfg_nshots;
            end
        end else if (ab) begin
            m_state = 0;
        end else if (ce) begin
            if (m_shot != int'(s_nshots) - 1) begin
                m_shot++;
            end else if (m_pt == int'(s_npts) - 1) begin
                m_state = 2;
            end else begin
                m_pt++;
                m_shot = 0;
                v = longint'(s_start) + longint'(m_pt) * longint'(s_step);
                if (v > 65535) begin
                    m_del = 16'hFFFF;
                    m_err = 1;
                end else begin
                    m_del = v[15:0];
                end
                exp_q.push_back('{m_del, 8'(m_pt)});
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(m_state == 1));
        chk({tag, "_done"}, 32'(done), 32'(m_state == 2));
        chk({tag, "_pt"}, 32'(pt_idx), 32'(m_pt));
        chk({tag, "_shot"}, 32'(shot_idx), 32'(m_shot));
        chk({tag, "_del"}, 32'(del_out), 32'(m_del));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    task automatic cyc(input bit ld, input bit st, input bit ab, input bit ce);
        cfg_load = ld; start = st; abort = ab; cycle_end = ce;
        @(posedge clk);
        model_step(ld, st, ab, ce);
        #1;
        cfg_load = 0; start = 0; abort = 0; cycle_end = 0;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] n, input logic [15:0] s);
        cfg_start = a; cfg_step = b; cfg_npts = n; cfg_nshots = s;
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        int base;
        reset = 1; cfg_load = 0; start = 0; abort = 0; cycle_end = 0;
        cfg_start = 0; cfg_step = 0; cfg_npts = 0; cfg_nshots = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_upd", 32'(del_upd), 0);
        check_all("rst");

        // basic three-point sweep
        load(16'd100, 16'd50, 8'd3, 16'd2);
        base = upd_seen;
        cyc(0, 1, 0, 0);
        check_all("t1_start");
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
            check_all("t1_run");
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_pt", 32'(pt_idx), 2);
        chk("t1_shot", 32'(shot_idx), 1);
        chk("t1_del", 32'(del_out), 200);
        chk("t1_updcnt", 32'(upd_seen - base), 3);

        // invalid configs
        load(16'd5, 16'd1, 8'd0, 16'd3);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_err_np", 32'(err), 1);
        check_all("t2a");
        load(16'd5, 16'd1, 8'd2, 16'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t2_err_ns", 32'(err), 1);
        check_all("t2b");
        load(16'd5, 16'd1, 8'd1, 16'd1);
        cyc(0, 1, 0, 0);
        chk("t2_err_clr", 32'(err), 0);
        cyc(0, 0, 0, 1);
        check_all("t2c");

        // saturating add
        load(16'hFFC0, 16'h0030, 8'd3, 16'd1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            check_all("t3");
        end
        chk("t3_sat", 32'(del_out), 32'hFFFF);
        chk("t3_err", 32'(err), 1);
        chk("t3_done", 32'(done), 1);

        // load ignored in RUN, abort beats cycle_end
        load(16'd10, 16'd5, 8'd4, 16'd3);
        cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 1);
        cfg_start = 16'd999; cfg_npts = 8'd1;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        check_all("t4_abort");
        chk("t4_pt", 32'(pt_idx), 1);
        chk("t4_shot", 32'(shot_idx), 1);
        cyc(0, 1, 0, 0);
        chk("t4_shadow", 32'(del_out), 10);

        // start together with cycle_end
        cyc(0, 0, 1, 0);
        load(16'd7, 16'd1, 8'd2, 16'd2);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t5_pt0", 32'(pt_idx), 0);
        cyc(0, 0, 0, 1);
        chk("t5_pt1", 32'(pt_idx), 1);
        check_all("t5");

        // async reset between edges
        #3 reset = 1;
        #1;
        chk("t6_del", 32'(del_out), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pt", 32'(pt_idx), 0);
        chk("t6_upd", 32'(del_upd), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t6_err", 32'(err), 1);
        check_all("t6");

        // randomized sweeps
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) == 0) ? 16'(16'hFF00 + $urandom_range(0, 255))
                                            : 16'($urandom);
            if (m_state == 1) cyc(0, 0, 1, 0);
            load(a, 16'($urandom_range(0, 200)), 8'($urandom_range(0, 5)),
                 16'($urandom_range(0, 4)));
            cyc(0, 1, 0, $urandom_range(0, 3) == 0);
            check_all("rnd_start");
            for (int c = 0; c < 60 && m_state == 1; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 40) cyc(0, 0, 0, 1);
                else if (r < 42) cyc(0, 0, 1, $urandom_range(0, 1) == 1);
                else if (r < 46) begin
                    cfg_start = 16'($urandom); cfg_npts = 8'($urandom);
                    cyc(1, 0, 0, 0);
                end else if (r < 49) cyc(0, 1, 0, 0);
                else cyc(0, 0, 0, 0);
                check_all("rnd");
            end
        end

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("q_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sweep_sched.md
Name: sweep_sched

Overview:
- Scheduler that steps the pulse-gen echo delay through a linear sweep and repeats each delay point for a programmed number of pulse periods (shots).
- Sits between the serial control block and the pulse generator.
- Shadow config is loaded on the control block's rx_done strobe.
- The block counts period-boundary strobes from the pulse generator and presents the current delay, plus an update strobe, to the pulse generator's delay input.

Parameters:
DEL_W, 16, width of delay value and step
PT_W, 8, width of point count and point index
SHOT_W, 16, width of shot count and shot index

Ports:
clk  input  1  pulse-gen base clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
cfg_load  input  1  one-cycle strobe (rx_done); capture cfg_* into shadow registers
cfg_start  input  DEL_W  first delay value, clk cycles
cfg_step  input  DEL_W  delay increment per point (unsigned)
cfg_npts  input  PT_W  number of sweep points
cfg_nshots  input  SHOT_W  periods per point
start  input  1  one-cycle strobe; begin sweep
abort  input  1  one-cycle strobe; stop sweep
cycle_end  input  1  one-cycle strobe at end of each pulse period (clk domain)
del_out  output  DEL_W  delay currently applied
del_upd  output  1  one-cycle strobe when del_out changes
pt_idx  output  PT_W  current point index
shot_idx  output  SHOT_W  current shot index within point
busy  output  1  high in RUN
done  output  1  sweep completed
err  output  1  sticky error flag

Behaviour:
- Reset (async assert, sync use after deassert):
  - state=IDLE.
  - Shadow registers = 0.
  - del_out, del_upd, pt_idx, shot_idx, busy, done and err all = 0.
- States:
  - IDLE: no sweep active.
  - RUN: sweep in progress.
  - DONE: sweep completed.
- cfg_load:
  - Accepted in IDLE or DONE only; captures all four cfg_* values in 1 cycle.
  - Ignored in RUN; the shadow is unchanged and the sweep is unaffected.
  - In DONE it also clears done and returns to IDLE.
- start in IDLE or DONE, with shadow npts=0 or nshots=0:
  - Set err=1 and stay in (or go to) IDLE.
  - busy and del_upd are not asserted.
- start in IDLE or DONE, valid shadow: on the next edge
  - state=RUN, busy=1, done=0;
  - del_out=shadow start, pt_idx=0, shot_idx=0;
  - del_upd=1 for exactly that one cycle.
- start in RUN: ignored.
- RUN, counting:
  - Each cycle_end increments shot_idx.
  - When cycle_end arrives with shot_idx==nshots-1 and pt_idx<npts-1:
    - shot_idx=0, pt_idx+1;
    - del_out = del_out + step, with del_upd pulsed the same cycle del_out changes.
  - Add is DEL_W+1 bits. On carry, del_out saturates to all-ones and err=1 (sticky); the sweep continues.
  - When cycle_end arrives with shot_idx==nshots-1 and pt_idx==npts-1:
    - state=DONE, busy=0, done=1;
    - del_out, pt_idx and shot_idx hold their last values; no del_upd.
- abort:
  - In RUN: next edge state=IDLE, busy=0, done=0. Indices and del_out hold; no del_upd.
  - Ignored elsewhere.
- Priorities on the same cycle:
  - abort > cycle_end; cycle_end is discarded.
  - start in IDLE/DONE together with cycle_end: start wins, that cycle_end is not counted. The first counted shot is the next cycle_end.
  - cfg_load together with start in IDLE/DONE: the load is captured and start uses the OLD shadow. A bench must not rely on same-cycle load+start.
- err:
  - Cleared only by reset or by a valid start.
  - A valid start clears err before the new sweep; any later overflow sets it again.
- npts=1: a single point; DONE after nshots cycle_ends; del_upd only at start.
- nshots=1: the point advances on every cycle_end.
- Reset mid-RUN: immediate return to reset values; del_upd never glitches high.
- Latency:
  - start → del_out/del_upd: 1 cycle.
  - cycle_end → point advance or DONE: 1 cycle.

Test Plan:
1. cfg_load start=100, step=50, npts=3, nshots=2; start; 6 cycle_end → del_out sequence 100, 150, 200; del_upd pulses exactly 3 times (at start, after cycle_end #2 and #4); done=1 after #6, busy=0, pt_idx=2, shot_idx=1.
2. cfg npts=0 or nshots=0, start → err=1, state IDLE, busy=0, no del_upd; next valid start → err=0.
3. start=0xFFC0, step=0x0030, npts=3, nshots=1 → del_out 0xFFC0, 0xFFF0, then 0xFFFF with err=1; done after 3 cycle_ends.
4. Mid-sweep abort on the same cycle as cycle_end → IDLE next edge, indices unchanged, busy=0, no del_upd; cfg_load while RUN (before abort) left shadow unchanged.
5. start asserted together with cycle_end → that cycle_end not counted; with nshots=2, point 1 appears only after the 2nd subsequent cycle_end.
6. Async reset asserted mid-RUN between clock edges → all outputs 0 immediately; after release, start with prior cfg → del_out=0, err=1 (shadow cleared by reset).
